// File: rtl/ahb_pkg.sv
// Shared types for the AHB-lite multi-requester master front end.
//   htrans_t    : AHB transfer type (only IDLE and NONSEQ are ever issued)
//   arb_state_t : sequencer states (arbitrate, address phase, data phase)
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      NONSEQ = 2'b10
   } htrans_t;

   typedef enum logic [1:0] {
      ARB  = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10
   } arb_state_t;

endpackage

// File: rtl/ahb_master_arb_rr_arbiter.sv
// Combinational round-robin picker.
//   req    : request vector (already masked by the caller)
//   ptr    : index where the search starts; wraps through nReq-1 back to 0
//   anyReq : at least one request present
//   winner : first requesting index at or after ptr
module rr_arbiter
   import ahb_pkg::*;
#(
   parameter  int unsigned nReq = 2,
   localparam int unsigned IdxW = $clog2(nReq)
) (
   input  logic [nReq-1:0] req,
   input  logic [IdxW-1:0] ptr,
   output logic            anyReq,
   output logic [IdxW-1:0] winner
);

   // Walk nReq candidates starting at ptr; first hit wins.
   always_comb begin
      int unsigned idx;
      anyReq = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < nReq; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= nReq) idx = idx - nReq;
         if (!anyReq && req[IdxW'(idx)]) begin
            anyReq = 1'b1;
            winner = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/ahb_master_arb.sv
// AHB-lite master front end sharing one slave port among nReq requesters.
// Round-robin arbitration, one non-pipelined NONSEQ transfer at a time,
// single-cycle one-hot ack with read data.
//   hclk, hresetn          : clock, async active-low reset
//   req/reqWrite/reqAddr/reqWdata : per-requester request (packed slices)
//   ack/ackRdata/ackErr    : completion pulse, read data, timeout flag
//   grantId                : current or last granted requester
//   hselx/htrans/haddr/hwrite/hwdata/hrdata/hready : AHB-lite slave pins
// Optional feature: define AHB_MASTER_ARB_TIMEOUT_EN to abort a transfer after
// timeoutCycles consecutive hready=0 cycles (ack with ackErr=1).
module ahb_master_arb
   import ahb_pkg::*;
#(
   parameter int unsigned nReq          = 2,
   parameter int unsigned addrWidth     = 8,
   parameter int unsigned dataWidth     = 32,
   parameter int unsigned timeoutCycles = 16
) (
   input  logic                        hclk,
   input  logic                        hresetn,
   input  logic [nReq-1:0]             req,
   input  logic [nReq-1:0]             reqWrite,
   input  logic [nReq*addrWidth-1:0]   reqAddr,
   input  logic [nReq*dataWidth-1:0]   reqWdata,
   output logic [nReq-1:0]             ack,
   output logic [dataWidth-1:0]        ackRdata,
   output logic                        ackErr,
   output logic [$clog2(nReq)-1:0]     grantId,
   output logic                        hselx,
   output logic [1:0]                  htrans,
   output logic [addrWidth-1:0]        haddr,
   output logic                        hwrite,
   output logic [dataWidth-1:0]        hwdata,
   input  logic [dataWidth-1:0]        hrdata,
   input  logic                        hready
);

   localparam int unsigned IdxW = $clog2(nReq);

   if (nReq < 2 || nReq > 8 || timeoutCycles < 1 || timeoutCycles > 255) begin : g_param_check
      $error("ahb_master_arb: parameter out of range");
   end

   arb_state_t             state_q, state_d;
   htrans_t                htrans_q, htrans_d;
   logic                   hselx_q, hselx_d;
   logic [addrWidth-1:0]   haddr_q, haddr_d;
   logic                   hwrite_q, hwrite_d;
   logic [dataWidth-1:0]   hwdata_q, hwdata_d;
   logic [dataWidth-1:0]   wdata_q, wdata_d;
   logic [nReq-1:0]        ack_q, ack_d;
   logic [dataWidth-1:0]   rdata_q, rdata_d;
   logic [IdxW-1:0]        grant_q, grant_d;
   logic [IdxW-1:0]        ptr_q, ptr_d;
   logic [nReq-1:0]        req_masked_c;
   logic                   any_req_c;
   logic [IdxW-1:0]        winner_c;
   logic                   timeout_c;

   // A requester being acked this cycle cannot win again in the same cycle.
   assign req_masked_c = req & ~ack_q;

   rr_arbiter #(.nReq(nReq)) u_rr_arbiter (
      .req    (req_masked_c),
      .ptr    (ptr_q),
      .anyReq (any_req_c),
      .winner (winner_c)
   );

`ifdef AHB_MASTER_ARB_TIMEOUT_EN
   localparam int unsigned         ToCntW = 8;
   localparam logic [ToCntW-1:0]   ToLast = ToCntW'(timeoutCycles - 1);
   logic [ToCntW-1:0]              to_cnt_q, to_cnt_d;
   logic                           err_q, err_d;

   // This stall is the timeoutCycles-th consecutive one.
   assign timeout_c = (state_q != ARB) && !hready && (to_cnt_q == ToLast);

   // Zero while arbitrating so every transfer starts from a clean count.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == ARB || hready) to_cnt_d = '0;
      else                          to_cnt_d = to_cnt_q + 1'b1;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end

   assign ackErr = err_q;
`else
   assign timeout_c = 1'b0;
   assign ackErr    = 1'b0;
`endif

   // State register.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state_q <= ARB;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (any_req_c) state_d = ADDR;
         ADDR:    if (hready) state_d = DATA;
                  else if (timeout_c) state_d = ARB;
         DATA:    if (hready || timeout_c) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // Output and holding-register next values.
   always_comb begin
      htrans_d = htrans_q;
      hselx_d  = hselx_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
      wdata_d  = wdata_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      ack_d    = '0;
      rdata_d  = '0;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
      err_d    = 1'b0;
`endif
      case (state_q)
         ARB: if (any_req_c) begin
            haddr_d  = reqAddr[32'(winner_c) * addrWidth +: addrWidth];
            hwrite_d = reqWrite[winner_c];
            wdata_d  = reqWdata[32'(winner_c) * dataWidth +: dataWidth];
            htrans_d = NONSEQ;
            hselx_d  = 1'b1;
            grant_d  = winner_c;
            ptr_d    = (winner_c == IdxW'(nReq - 1)) ? '0 : winner_c + 1'b1;
         end
         ADDR: if (hready) begin
            htrans_d = IDLE;
            hselx_d  = 1'b0;
            hwdata_d = hwrite_q ? wdata_q : '0;
         end else if (timeout_c) begin
            htrans_d = IDLE;
            hselx_d  = 1'b0;
            ack_d    = nReq'(1) << grant_q;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
            err_d    = 1'b1;
`endif
         end
         DATA: if (hready) begin
            ack_d    = nReq'(1) << grant_q;
            rdata_d  = hwrite_q ? '0 : hrdata;
         end else if (timeout_c) begin
            ack_d    = nReq'(1) << grant_q;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
            err_d    = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // Output and holding registers.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         htrans_q <= IDLE;
         hselx_q  <= 1'b0;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
         wdata_q  <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
         grant_q  <= '0;
         ptr_q    <= '0;
      end else begin
         htrans_q <= htrans_d;
         hselx_q  <= hselx_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hwdata_q <= hwdata_d;
         wdata_q  <= wdata_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
      end
   end

   assign htrans   = htrans_q;
   assign hselx    = hselx_q;
   assign haddr    = haddr_q;
   assign hwrite   = hwrite_q;
   assign hwdata   = hwdata_q;
   assign ack      = ack_q;
   assign ackRdata = rdata_q;
   assign grantId  = grant_q;

endmodule

// File: tb/tb_ahb_master_arb.sv
// Bench for ahb_master_arb: transaction-level model + memory slave, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ahb_master_arb;

   localparam int unsigned NR = 2;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic              hclk = 1'b0;
   logic              hresetn;
   logic [NR-1:0]     req, reqWrite;
   logic [NR*AW-1:0]  reqAddr;
   logic [NR*DW-1:0]  reqWdata;
   logic [NR-1:0]     ack;
   logic [DW-1:0]     ackRdata;
   logic              ackErr;
   logic [0:0]        grantId;
   logic              hselx;
   logic [1:0]        htrans;
   logic [AW-1:0]     haddr;
   logic              hwrite;
   logic [DW-1:0]     hwdata;
   logic [DW-1:0]     hrdata;
   logic              hready;

   ahb_master_arb #(.nReq(NR), .addrWidth(AW), .dataWidth(DW), .timeoutCycles(TO)) dut (
      .hclk(hclk), .hresetn(hresetn), .req(req), .reqWrite(reqWrite),
      .reqAddr(reqAddr), .reqWdata(reqWdata), .ack(ack), .ackRdata(ackRdata),
      .ackErr(ackErr), .grantId(grantId), .hselx(hselx), .htrans(htrans),
      .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
      .hready(hready)
   );

   always #5 hclk = ~hclk;

   int total = 0;
   int bad   = 0;

   // Reference model: one outstanding transaction, round-robin pointer.
   bit            m_busy;
   int            m_phase;   // 0 address phase, 1 data phase
   int            m_id;
   logic [AW-1:0] m_addr;
   bit            m_wr;
   logic [DW-1:0] m_wdata;
   int            m_ptr;
   int            m_stall;
   logic [1:0]    e_htrans;
   logic [AW-1:0] e_haddr;
   bit            e_hwrite;
   logic [NR-1:0] e_ack;
   logic [DW-1:0] e_rdata;
   bit            e_err;
   int            e_grant;
   logic [DW-1:0] m_mem  [256];

   // Memory slave driven purely from the bus pins.
   logic [DW-1:0] sl_mem [256];
   bit            s_dph;
   logic [AW-1:0] s_addr;
   bit            s_wr;
   bit            p_hselx;
   logic [AW-1:0] p_haddr;
   bit            p_hwrite;
   logic [DW-1:0] p_hwdata;

   int rr0, rr1, zrun;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_phase = 0; m_id = 0; m_ptr = 0; m_stall = 0;
      e_htrans = 2'b00; e_haddr = '0; e_hwrite = 0; e_ack = '0;
      e_rdata = '0; e_err = 0; e_grant = 0;
   endtask

   // Advance the model by one clock edge using the inputs the DUT just sampled.
   task automatic model_step();
      logic [NR-1:0] cand, n_ack;
      logic [DW-1:0] n_rdata;
      bit            n_err;
      int            i;
      n_ack = '0; n_rdata = '0; n_err = 0;
      if (!m_busy) begin
         cand = req & ~e_ack;
         for (int k = 0; k < NR; k++) begin
            i = (m_ptr + k) % NR;
            if (!m_busy && cand[i]) begin
               m_busy = 1; m_phase = 0; m_id = i; m_stall = 0;
               m_addr = reqAddr[i*AW +: AW];
               m_wr = reqWrite[i];
               m_wdata = reqWdata[i*DW +: DW];
               m_ptr = (i + 1) % NR;
               e_grant = i; e_htrans = 2'b10; e_haddr = m_addr; e_hwrite = m_wr;
            end
         end
      end else if (hready) begin
         m_stall = 0;
         if (m_phase == 0) begin
            m_phase = 1;
            e_htrans = 2'b00;
         end else begin
            m_busy = 0;
            n_ack[m_id] = 1'b1;
            if (m_wr) m_mem[m_addr] = m_wdata;
            else      n_rdata = m_mem[m_addr];
         end
      end else begin
         m_stall++;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
         if (m_stall == TO) begin
            m_busy = 0; e_htrans = 2'b00; n_ack[m_id] = 1'b1; n_err = 1;
         end
`endif
      end
      e_ack = n_ack; e_rdata = n_rdata; e_err = n_err;
   endtask

   task automatic compare();
      chk("htrans", htrans, e_htrans);
      chk("hselx", hselx, e_htrans == 2'b10);
      chk("ack", ack, e_ack);
      chk("ackRdata", ackRdata, e_rdata);
      chk("ackErr", ackErr, e_err);
      chk("grantId", grantId, e_grant);
      if (e_htrans == 2'b10) begin
         chk("haddr", haddr, e_haddr);
         chk("hwrite", hwrite, e_hwrite);
      end
      if (m_busy && m_phase == 1 && m_wr) chk("hwdata", hwdata, m_wdata);
   endtask

   // One clock: step model and slave on the edge, check outputs just after it.
   task automatic cycle();
      @(posedge hclk);
      #1;
      model_step();
      if (s_dph) begin
         if (hready) begin
            if (s_wr) sl_mem[s_addr] = p_hwdata;
            s_dph = 0;
         end
      end else if (p_hselx && hready) begin
         s_dph = 1; s_addr = p_haddr; s_wr = p_hwrite;
      end
      compare();
      p_hselx = hselx; p_haddr = haddr; p_hwrite = hwrite; p_hwdata = hwdata;
      hrdata = (s_dph && !s_wr) ? sl_mem[s_addr] : DW'($urandom);
   endtask

   task automatic apply_reset();
      hresetn = 1'b0;
      #1;
      chk("rst_htrans", htrans, 2'b00);
      chk("rst_hselx", hselx, 0);
      chk("rst_haddr", haddr, 0);
      chk("rst_hwrite", hwrite, 0);
      chk("rst_hwdata", hwdata, 0);
      chk("rst_ack", ack, 0);
      chk("rst_ackRdata", ackRdata, 0);
      chk("rst_ackErr", ackErr, 0);
      chk("rst_grantId", grantId, 0);
      model_reset();
      s_dph = 0; p_hselx = 0; p_haddr = '0; p_hwrite = 0; p_hwdata = '0;
      req = '0; hready = 1'b1; zrun = 0;
      repeat (2) @(posedge hclk);
      #2;
      hresetn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] v;
      logic [1:0]    rr_exp [4];
      rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
      req = '0; reqWrite = '0; reqAddr = '0; reqWdata = '0;
      hready = 1'b1; hrdata = '0; hresetn = 1'b0;
      rr0 = 0; rr1 = 0; zrun = 0;
      for (int a = 0; a < 256; a++) begin
         v = $urandom;
         m_mem[a] = v;
         sl_mem[a] = v;
      end
      m_mem[8'h20] = 32'h12345678;
      sl_mem[8'h20] = 32'h12345678;
      apply_reset();

      // Single write then read by requester 0.
      req = 2'b01; reqWrite = 2'b01;
      reqAddr[0 +: AW] = 8'h10; reqWdata[0 +: DW] = 32'hDEADBEEF;
      cycle();
      chk("lit_wr_htrans", htrans, 2'b10);
      chk("lit_wr_haddr", haddr, 8'h10);
      req = 2'b00; reqWrite = NR'($urandom); reqWdata[0 +: DW] = $urandom;
      cycle();
      chk("lit_wr_hwdata", hwdata, 32'hDEADBEEF);
      chk("lit_wr_ack_early", ack, 0);
      cycle();
      chk("lit_wr_ack", ack, 2'b01);
      chk("lit_wr_rdata", ackRdata, 0);
      cycle();
      chk("lit_wr_ack_drop", ack, 0);
      req = 2'b01; reqWrite = 2'b00; reqAddr[0 +: AW] = 8'h10;
      cycle();
      req = 2'b00;
      cycle();
      cycle();
      chk("lit_rd_ack", ack, 2'b01);
      chk("lit_rd_data", ackRdata, 32'hDEADBEEF);
      cycle();
      chk("lit_rd_data_clear", ackRdata, 0);

      // Round-robin with both requesting continuously (pointer is at 1 now).
      req = 2'b11; reqWrite = 2'b00;
      reqAddr[0 +: AW] = 8'h10; reqAddr[AW +: AW] = 8'h10;
      for (int c = 1; c <= 12; c++) begin
         cycle();
         if (ack[0]) rr0++;
         if (ack[1]) rr1++;
         if (c % 3 == 0) chk("lit_rr_ack", ack, rr_exp[c/3 - 1]);
      end
      req = 2'b00;
      chk("lit_rr_cnt0", rr0, 2);
      chk("lit_rr_cnt1", rr1, 2);

      // Two data-phase wait states on a read of 0x20.
      req = 2'b10; reqWrite = 2'b00; reqAddr[AW +: AW] = 8'h20;
      cycle();
      req = 2'b00;
      cycle();
      hready = 1'b0;
      cycle();
      chk("lit_ws_ack0", ack, 0);
      cycle();
      chk("lit_ws_ack1", ack, 0);
      hready = 1'b1;
      cycle();
      chk("lit_ws_ack", ack, 2'b10);
      chk("lit_ws_data", ackRdata, 32'h12345678);
      cycle();

      // Requester 1 holds req through its own ack cycle.
      req = 2'b10; reqWrite = 2'b10; reqWdata[DW +: DW] = $urandom;
      cycle();
      cycle();
      cycle();
      chk("lit_mask_ack", ack, 2'b10);
      cycle();
      chk("lit_mask_nogrant", htrans, 2'b00);
      cycle();
      chk("lit_mask_regrant", htrans, 2'b10);
      chk("lit_mask_grantid", grantId, 1);
      req = 2'b00;
      cycle();
      cycle();
      chk("lit_mask_ack2", ack, 2'b10);
      cycle();

      // Reset during the data phase of a write to 0x30.
      req = 2'b01; reqWrite = 2'b01; reqAddr[0 +: AW] = 8'h30; reqWdata[0 +: DW] = $urandom;
      cycle();
      req = 2'b00;
      cycle();
      apply_reset();
      req = 2'b10; reqWrite = 2'b00; reqAddr[AW +: AW] = 8'h05;
      cycle();
      chk("lit_rst_grant", grantId, 1);
      chk("lit_rst_htrans", htrans, 2'b10);
      req = 2'b00;
      cycle();
      cycle();
      chk("lit_rst_ack", ack, 2'b10);
      cycle();

`ifdef AHB_MASTER_ARB_TIMEOUT_EN
      // Slave never ready: abort after TO stalled cycles, then recover.
      req = 2'b01; reqWrite = 2'b00; reqAddr[0 +: AW] = 8'h20;
      hready = 1'b0;
      cycle();
      req = 2'b00;
      for (int s = 0; s < 3; s++) begin
         cycle();
         chk("lit_to_wait", ack, 0);
      end
      cycle();
      chk("lit_to_ack", ack, 2'b01);
      chk("lit_to_err", ackErr, 1);
      chk("lit_to_htrans", htrans, 2'b00);
      chk("lit_to_rdata", ackRdata, 0);
      hready = 1'b1;
      cycle();
      req = 2'b01;
      cycle();
      req = 2'b00;
      cycle();
      cycle();
      chk("lit_to_next_ack", ack, 2'b01);
      chk("lit_to_next_err", ackErr, 0);
      chk("lit_to_next_data", ackRdata, 32'h12345678);
      cycle();
`endif

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         req = NR'($urandom);
         reqWrite = NR'($urandom);
         for (int r = 0; r < NR; r++) begin
            reqAddr[r*AW +: AW] = AW'($urandom_range(0, 15));
            reqWdata[r*DW +: DW] = $urandom;
         end
         if (zrun >= 2) hready = 1'b1;
         else           hready = ($urandom_range(0, 3) != 0);
         zrun = hready ? 0 : zrun + 1;
         if ($urandom_range(0, 499) == 0) apply_reset();
         cycle();
      end
      req = '0; hready = 1'b1;
      repeat (6) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
